procesador_integration_sequencer: RTL and testbench
===================================================

Name: procesador_integration_sequencer

Overview:
Avalon-MM-controlled sequencer for the frame-integration (coherent averaging) accumulator. The Nios processor programs the number of frames N and issues start. The block then aligns to start-of-frame (SOF) on the sample stream and drives clear/enable strobes to the accumulator datapath for N frames of SAMPLES_PER_FRAME samples. It signals completion via status and a one-cycle result strobe.

Parameters:
SAMPLES_PER_FRAME, 1024, valid samples per frame; legal range 1..65535.
CNT_W, 16, sample counter width; must satisfy 2^CNT_W > SAMPLES_PER_FRAME.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  Avalon-MM word address
chipselect  in  1  Avalon-MM select
write_n  in  1  Avalon-MM write, active low
writedata  in  32  Avalon-MM write data
readdata  out  32  Avalon-MM read data, combinational, zero wait states
in_valid  in  1  sample strobe from ADC stream
in_sof  in  1  first sample of frame; qualified by in_valid
acc_clr  out  1  one-cycle accumulator clear
acc_en  out  1  accumulate current sample (combinational)
frame_idx  out  8  index of frame being accumulated
result_valid  out  1  one-cycle pulse: integration complete
busy  out  1  sequencer active

Behaviour:
- Register map (write = chipselect & ~write_n):
  - 0 CTRL: write-only, reads 0. bit0 START (self-clearing), bit1 ABORT.
  - 1 NFRAMES: r/w, bits[7:0], reset 1. Value 0 is treated as 1.
  - 2 STATUS: bit0 busy (RO), bit1 done (W1C), bit2 sof_err (W1C), bit3 irq_en (r/w, see feature).
  - 3 COUNT: RO. [7:0] frames completed, [23:8] sample count within current frame.
  - Unused readdata bits are 0.
- Reset values: all outputs 0; state IDLE; NFRAMES=1; done, sof_err, irq_en, counters 0.
- FSM:
  - IDLE: START → WAIT_SOF. On that transition: N latched from NFRAMES; counters cleared; done cleared; acc_clr=1 in the following cycle.
  - WAIT_SOF: in_valid & in_sof → ACCUM. That sample is accepted (acc_en=1), so sample count becomes 1.
  - ACCUM: each in_valid gives acc_en=1 and sample count +1.
    - On the SAMPLES_PER_FRAME-th sample: sample count → 0 and frame_idx +1.
    - If that was frame N-1: → DONE. Otherwise the next frame begins on the next in_valid (SOF not required).
  - DONE: one cycle. result_valid=1, done set → IDLE.
- acc_en = in_valid & (state==ACCUM | (state==WAIT_SOF & in_sof)); zero latency.
- busy = 1 in WAIT_SOF and ACCUM, and in the acc_clr cycle.
- in_sof while in ACCUM at sample count ≠ 0: sof_err set (sticky). The sample is still accumulated and counting is not resynchronised.
- ABORT in any state: → IDLE next cycle. No result_valid; done not set; frame_idx holds. ABORT wins over simultaneous START.
- START while busy: ignored.
- NFRAMES writes while busy: no effect on the current run; applied at the next START.
- Reset mid-run: immediate return to IDLE with all outputs 0.
- Frame counter width 8; N=255 max; no wrap.

Optional Feature:
INTEG_IRQ_EN.
- Defined: adds output port irq (1 bit, level). irq = done & irq_en. Cleared by W1C of done or by START.
- Undefined: no irq port; STATUS bit3 reads 0 and ignores writes.

Test Plan:
1. Reset → readdata at addr1=1, addr2=0; busy, acc_en, acc_clr, result_valid all 0.
2. SAMPLES_PER_FRAME=4, NFRAMES=3, START, then continuous in_valid with in_sof on the first sample → acc_clr 1 cycle after START; 12 acc_en cycles; result_valid 1 cycle after the 12th sample; STATUS=0x2; COUNT[7:0]=3.
3. START with in_valid toggling and no in_sof for 20 cycles → stays WAIT_SOF, acc_en=0, busy=1. Then in_sof → accumulation begins.
4. ABORT during frame 1 (NFRAMES=3) → busy=0 next cycle, no result_valid, done=0. START+ABORT in the same write → remains IDLE.
5. in_sof at sample 2 of 4 inside ACCUM → sof_err=1, run still completes after 4·N samples. Write 0x4 to STATUS → sof_err=0.
6. NFRAMES=0 → single frame completes. With INTEG_IRQ_EN and irq_en=1 → irq high after DONE until done is written 1.

Source files
------------

// File: rtl/procesador_integration_sequencer.sv
// Frame-integration sequencer: Avalon-MM control, SOF alignment, acc strobes.
// Optional level irq output when INTEG_IRQ_EN is defined.
module procesador_integration_sequencer #(
  parameter int SAMPLES_PER_FRAME = 1024,
  parameter int CNT_W             = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        in_valid,
  input  logic        in_sof,
  output logic        acc_clr,
  output logic        acc_en,
  output logic [7:0]  frame_idx,
  output logic        result_valid,
`ifdef INTEG_IRQ_EN
  output logic        irq,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACC,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] smp_q, smp_d;
  logic [7:0]       frm_q, frm_d;
  logic [7:0]       n_q, n_d;
  logic [7:0]       nfr_q, nfr_d;
  logic             clr_q, clr_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             irq_en_q;
`ifdef INTEG_IRQ_EN
  logic             irq_en_d;
`else
  assign irq_en_q = 1'b0;
`endif

  logic        wr, start, abort, last_smp;
  logic [15:0] cnt16;
  logic        unused_ok;

  assign wr       = chipselect & ~write_n;
  assign abort    = wr & (address == 2'd0) & writedata[1];
  assign start    = wr & (address == 2'd0) & writedata[0];
  assign last_smp = (smp_q == CNT_W'(SAMPLES_PER_FRAME - 1));
  assign cnt16    = 16'(smp_q);
  assign unused_ok = ^{writedata[31:8], writedata[3]};

  assign acc_en = in_valid &
                  ((state_q == S_ACC) | ((state_q == S_WAIT) & in_sof));
  assign busy = clr_q | (state_q == S_WAIT) | (state_q == S_ACC);
  assign acc_clr      = clr_q;
  assign frame_idx    = frm_q;
  assign result_valid = (state_q == S_DONE);
`ifdef INTEG_IRQ_EN
  assign irq = done_q & irq_en_q;
`endif

  // State and control/status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      smp_q    <= '0;
      frm_q    <= '0;
      n_q      <= 8'd1;
      nfr_q    <= 8'd1;
      clr_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef INTEG_IRQ_EN
      irq_en_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      smp_q    <= smp_d;
      frm_q    <= frm_d;
      n_q      <= n_d;
      nfr_q    <= nfr_d;
      clr_q    <= clr_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef INTEG_IRQ_EN
      irq_en_q <= irq_en_d;
`endif
    end
  end

  // Register writes, then sequencing; FSM sets win over W1C.
  always_comb begin
    state_d  = state_q;
    smp_d    = smp_q;
    frm_d    = frm_q;
    n_d      = n_q;
    nfr_d    = nfr_q;
    clr_d    = 1'b0;
    done_d   = done_q;
    err_d    = err_q;
`ifdef INTEG_IRQ_EN
    irq_en_d = irq_en_q;
`endif
    if (wr && address == 2'd1) nfr_d = writedata[7:0];
    if (wr && address == 2'd2) begin
      if (writedata[1]) done_d = 1'b0;
      if (writedata[2]) err_d = 1'b0;
`ifdef INTEG_IRQ_EN
      irq_en_d = writedata[3];
`endif
    end
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_WAIT;
            n_d     = (nfr_q == 8'd0) ? 8'd1 : nfr_q;
            smp_d   = '0;
            frm_d   = '0;
            done_d  = 1'b0;
            clr_d   = 1'b1;
          end
        end
        S_WAIT, S_ACC: begin
          if (acc_en) begin
            if (state_q == S_ACC && in_sof && smp_q != '0) err_d = 1'b1;
            state_d = S_ACC;
            if (last_smp) begin
              smp_d = '0;
              frm_d = frm_q + 8'd1;
              if (frm_q == n_q - 8'd1) state_d = S_DONE;
            end else begin
              smp_d = smp_q + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Zero-wait-state read mux.
  always_comb begin
    readdata = '0;
    unique case (address)
      2'd0: readdata = '0;
      2'd1: readdata = {24'd0, nfr_q};
      2'd2: readdata = {28'd0, irq_en_q, err_q, done_q, busy};
      2'd3: readdata = {8'd0, cnt16, frm_q};
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_procesador_integration_sequencer.sv
// Bench for procesador_integration_sequencer: register table, directed
// run sequences and randomized traffic against a sample-count model.
module tb_procesador_integration_sequencer;

  localparam int SPF = 4;
`ifdef INTEG_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif
  localparam logic [31:0] IRQB = HAS_IRQ ? 32'd8 : 32'd0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic        acc_clr, acc_en, result_valid, busy;
  logic [7:0]  frame_idx;
  logic        irq_s;
`ifdef INTEG_IRQ_EN
  logic        irq;
  assign irq_s = irq;
`else
  assign irq_s = 1'b0;
`endif

  procesador_integration_sequencer #(
    .SAMPLES_PER_FRAME(SPF),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .in_valid(in_valid),
    .in_sof(in_sof),
    .acc_clr(acc_clr),
    .acc_en(acc_en),
    .frame_idx(frame_idx),
    .result_valid(result_valid),
`ifdef INTEG_IRQ_EN
    .irq(irq),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // model: k = samples accepted in this run; frame = k/SPF
  int m_k, m_n, m_nf;
  bit m_active, m_wait, m_clr, m_fin, m_done, m_err, m_irqen;

  bit          obs_en, obs_clr, obs_busy, obs_rv, obs_irq;
  logic [7:0]  obs_frm;
  logic [31:0] obs_rd;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mreset();
    m_k = 0; m_n = 1; m_nf = 1;
    m_active = 0; m_wait = 0; m_clr = 0; m_fin = 0;
    m_done = 0; m_err = 0; m_irqen = 0;
  endtask

  // One clock: drive, check against model at negedge, advance model.
  task automatic cyc(input bit cs, input bit wn, input logic [1:0] a,
                     input logic [31:0] wd, input bit v, input bit s);
    bit e, wr, ab, st, mb;
    logic [31:0] erd;
    logic [7:0] efrm;
    chipselect = cs; write_n = wn; address = a; writedata = wd;
    in_valid = v; in_sof = s;
    @(negedge clk);
    e = v & ((m_active & !m_wait) | (m_wait & s));
    mb = m_active | m_clr;
    efrm = 8'(m_k / SPF);
    case (a)
      2'd1: erd = 32'(m_nf);
      2'd2: erd = {28'd0, m_irqen, m_err, m_done, mb};
      2'd3: erd = 32'((m_k % SPF) * 256) | 32'(efrm);
      default: erd = '0;
    endcase
    obs_en = acc_en; obs_clr = acc_clr; obs_busy = busy;
    obs_rv = result_valid; obs_frm = frame_idx; obs_rd = readdata;
    obs_irq = irq_s;
    chk("cycle", {19'd0, irq_s, acc_en, acc_clr, busy, result_valid,
                  frame_idx, readdata},
        {19'd0, m_done & m_irqen, e, m_clr, mb, m_fin, efrm, erd});
    wr = cs & ~wn;
    ab = wr & (a == 2'd0) & wd[1];
    st = wr & (a == 2'd0) & wd[0];
    if (wr && a == 2'd1) m_nf = int'(wd[7:0]);
    if (wr && a == 2'd2) begin
      if (wd[1]) m_done = 0;
      if (wd[2]) m_err = 0;
      if (HAS_IRQ) m_irqen = wd[3];
    end
    m_clr = 0;
    if (ab) begin
      m_active = 0; m_wait = 0; m_fin = 0;
    end else if (m_fin) begin
      m_fin = 0; m_done = 1;
    end else if (!m_active) begin
      if (st) begin
        m_active = 1; m_wait = 1; m_k = 0; m_done = 0; m_clr = 1;
        m_n = (m_nf == 0) ? 1 : m_nf;
      end
    end else if (e) begin
      if (!m_wait && s && (m_k % SPF) != 0) m_err = 1;
      m_wait = 0;
      m_k++;
      if (m_k == m_n * SPF) begin
        m_active = 0; m_fin = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wrr(input logic [1:0] a, input logic [31:0] d);
    cyc(1, 0, a, d, 0, 0);
  endtask
  task automatic rdr(input logic [1:0] a);
    cyc(1, 1, a, 32'd0, 0, 0);
  endtask
  task automatic idle(input bit v, input bit s);
    cyc(0, 1, 2'd0, 32'd0, v, s);
  endtask

  typedef struct {
    logic [1:0]  a;
    bit          w;
    logic [31:0] wd;
    bit          v;
    bit          s;
    logic [31:0] exp_rd;
    bit          exp_busy;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n_en, n_rv, n_clr, n_wait;
    tbl[0]  = '{2'd1, 0, 32'd0,     0, 0, 32'd1,    0};
    tbl[1]  = '{2'd2, 0, 32'd0,     1, 1, 32'd0,    0};
    tbl[2]  = '{2'd0, 0, 32'd0,     0, 0, 32'd0,    0};
    tbl[3]  = '{2'd3, 0, 32'd0,     1, 0, 32'd0,    0};
    tbl[4]  = '{2'd1, 1, 32'h1FF,   0, 0, 32'd1,    0};
    tbl[5]  = '{2'd1, 0, 32'd0,     0, 0, 32'hFF,   0};
    tbl[6]  = '{2'd2, 1, 32'hE,     0, 0, 32'd0,    0};
    tbl[7]  = '{2'd2, 0, 32'd0,     0, 0, IRQB,     0};
    tbl[8]  = '{2'd2, 1, 32'd0,     0, 0, IRQB,     0};
    tbl[9]  = '{2'd2, 0, 32'd0,     0, 0, 32'd0,    0};
    tbl[10] = '{2'd1, 1, 32'd3,     0, 0, 32'hFF,   0};
    tbl[11] = '{2'd0, 1, 32'd3,     1, 1, 32'd0,    0};
    tbl[12] = '{2'd2, 0, 32'd0,     1, 1, 32'd0,    0};
    tbl[13] = '{2'd1, 0, 32'd0,     0, 0, 32'd3,    0};

    mreset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {acc_en, acc_clr, busy, result_valid, frame_idx},
        12'd0);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      cyc(1, !tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].v, tbl[i].s);
      chk($sformatf("tbl%0d", i), {obs_busy, obs_rd},
          {tbl[i].exp_busy, tbl[i].exp_rd});
    end

    // 3 frames of 4 continuous samples
    n_en = 0; n_rv = 0; n_clr = 0;
    wrr(2'd0, 32'd1);
    idle(0, 0);
    chk("clr_after_start", {obs_clr, obs_busy}, 2'b11);
    for (int i = 0; i < 12; i++) begin
      idle(1, i == 0);
      n_en += int'(obs_en);
    end
    idle(0, 0);
    chk("rv_after_12th", obs_rv, 1);
    for (int i = 0; i < 3; i++) begin
      idle(0, 0);
      n_rv += int'(obs_rv);
      n_clr += int'(obs_clr);
    end
    chk("acc_en_count", n_en, 12);
    chk("rv_once", n_rv + n_clr, 0);
    rdr(2'd2);
    chk("status_done", obs_rd, 32'h2);
    rdr(2'd3);
    chk("count_frames", obs_rd, 32'h3);

    // no SOF: stays waiting
    wrr(2'd0, 32'd1);
    n_wait = 0;
    for (int i = 0; i < 20; i++) begin
      idle(i[0], 0);
      if (!obs_en && obs_busy) n_wait++;
    end
    chk("wait_sof", n_wait, 20);
    idle(1, 1);
    chk("sof_accept", obs_en, 1);
    wrr(2'd0, 32'd2);
    idle(0, 0);
    chk("abort_idle", obs_busy, 0);

    // abort during frame 1
    wrr(2'd0, 32'd1);
    idle(0, 0);
    for (int i = 0; i < 5; i++) idle(1, i == 0);
    wrr(2'd0, 32'd2);
    idle(1, 0);
    chk("abort_busy_frm", {obs_busy, obs_en, obs_frm}, {2'b00, 8'd1});
    n_rv = 0;
    for (int i = 0; i < 6; i++) begin
      idle(1, 0);
      n_rv += int'(obs_rv);
    end
    chk("abort_no_rv", n_rv, 0);
    rdr(2'd2);
    chk("abort_status", obs_rd, 32'h0);

    // SOF error mid-frame, N=1
    wrr(2'd1, 32'd1);
    wrr(2'd0, 32'd1);
    idle(0, 0);
    for (int i = 0; i < 4; i++) idle(1, i == 0 || i == 1);
    idle(0, 0);
    chk("sof_err_rv", obs_rv, 1);
    rdr(2'd2);
    chk("sof_err_status", obs_rd, 32'h6);
    wrr(2'd2, 32'h4);
    rdr(2'd2);
    chk("sof_err_w1c", obs_rd, 32'h2);

    // NFRAMES=0 behaves as 1; irq when enabled
    wrr(2'd1, 32'd0);
    wrr(2'd2, 32'h8);
    wrr(2'd0, 32'd1);
    idle(0, 0);
    for (int i = 0; i < 4; i++) idle(1, i == 0);
    idle(0, 0);
    chk("n0_rv", obs_rv, 1);
    idle(0, 0);
    chk("n0_frame", obs_frm, 8'd1);
    rdr(2'd2);
    chk("n0_status", obs_rd, 32'h2 | IRQB);
    chk("irq_high", obs_irq, HAS_IRQ);
    wrr(2'd2, 32'h2);
    idle(0, 0);
    chk("irq_clear", {obs_irq, obs_busy}, 2'b00);

    // asynchronous reset mid-run
    wrr(2'd1, 32'd2);
    wrr(2'd0, 32'd1);
    idle(0, 0);
    idle(1, 1);
    idle(1, 0);
    in_valid = 1'b1; in_sof = 1'b1; chipselect = 1'b0; address = 2'd1;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid", {acc_en, acc_clr, busy, result_valid, frame_idx,
                    readdata}, {12'd0, 32'd1});
    mreset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic [1:0] a;
      logic [31:0] d;
      bit w;
      w = ($urandom % 12) == 0;
      a = 2'($urandom);
      d = $urandom;
      if (a == 2'd0) d = (($urandom % 10) == 0) ? 32'd2 : (d & ~32'd2) | 32'd1;
      if (a == 2'd1) d = d & 32'hFFFF_FF03;
      cyc(w | (($urandom % 3) == 0), !w, a, d,
          ($urandom % 4) != 0, ($urandom % 6) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
